cache_sram: RTL and testbench

Set-array storage and access sequencer for the variable-associativity data cache. Holds SETS sets of WAYS frames (valid, dirty, tag, WORDS data words). Serves one read or write of a full set at a time with a fixed, parameterised latency, and reports progress on `sramstate`. Sits directly below the dcache controller on its `cache_sram` modport: the controller issues `sramREN`/`sramWEN`, waits for `sramstate == ACCESS`, then evaluates `cacheline`.

---
 rtl/cache_types_package.sv | 52 +++++
 rtl/cache_sram_way.sv | 78 +++++++
 rtl/cache_sram.sv | 175 +++++++++++++++++
 tb/tb_cache_sram.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_types_package.sv
// Shared types for the data cache set array.
//   word_t       : 32-bit data word
//   frame_t      : one way of one set (v, dirty, tag, data words)
//   cacheline_t  : all ways of one set
//   sramstate_t  : progress code seen by the dcache controller
//   fsm_t        : internal sequencer state of cache_sram
package cache_types_package;

  localparam int unsigned CACHE_WAYS  = 2;
  localparam int unsigned CACHE_SETS  = 16;
  localparam int unsigned CACHE_WORDS = 4;
  localparam int unsigned CACHE_TAG_W = 26;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic                               v;
    logic                               dirty;
    logic [CACHE_TAG_W-1:0]             tag;
    word_t [CACHE_WORDS-1:0]            data;
  } frame_t;

  typedef struct packed {
    frame_t [CACHE_WAYS-1:0] set;
  } cacheline_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    INIT   = 2'd3
  } sramstate_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RBUSY,
    S_WBUSY,
    S_DONE
  } fsm_t;

  // Externally visible progress code for a sequencer state.
  function automatic sramstate_t sram_encode(input fsm_t s);
    case (s)
      S_INIT:           return INIT;
      S_RBUSY, S_WBUSY: return BUSY;
      S_DONE:           return ACCESS;
      default:          return FREE;
    endcase
  endfunction

endpackage

// File: rtl/cache_sram_way.sv
// Storage for one way of the set array: SETS frames.
// Tag and data words are never reset. With CACHE_SRAM_INIT_EN defined the
// v/dirty bits are plain storage cleared one set at a time through clr;
// otherwise they are cleared asynchronously by nRST.
// Ports:
//   CLK       clock
//   nRST      async active-low reset of v/dirty (only without CACHE_SRAM_INIT_EN)
//   clr       clear v/dirty at addr (only with CACHE_SRAM_INIT_EN)
//   we        write wframe into frame addr
//   addr      frame index for write, clear and read
//   wframe    frame to write
//   rframe_c  combinational read of frame addr
module cache_sram_way
  import cache_types_package::*;
#(
  parameter int unsigned SETS  = CACHE_SETS,
  parameter int unsigned TAG_W = CACHE_TAG_W,
  parameter int unsigned WORDS = CACHE_WORDS
) (
  input  logic                    CLK,
`ifdef CACHE_SRAM_INIT_EN
  input  logic                    clr,
`else
  input  logic                    nRST,
`endif
  input  logic                    we,
  input  logic [$clog2(SETS)-1:0] addr,
  input  frame_t                  wframe,
  output frame_t                  rframe_c
);

  logic [SETS-1:0]        v_q;
  logic [SETS-1:0]        dirty_q;
  logic [TAG_W-1:0]       tag_q  [SETS];
  word_t [WORDS-1:0]      data_q [SETS];

`ifdef CACHE_SRAM_INIT_EN
  // Status bits without reset; the INIT sweep clears them.
  always_ff @(posedge CLK) begin
    if (clr) begin
      v_q[addr]     <= 1'b0;
      dirty_q[addr] <= 1'b0;
    end else if (we) begin
      v_q[addr]     <= wframe.v;
      dirty_q[addr] <= wframe.dirty;
    end
  end
`else
  // Status bits cleared directly by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q     <= '0;
      dirty_q <= '0;
    end else if (we) begin
      v_q[addr]     <= wframe.v;
      dirty_q[addr] <= wframe.dirty;
    end
  end
`endif

  // Tag and data payload, no reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      tag_q[addr]  <= wframe.tag;
      data_q[addr] <= wframe.data;
    end
  end

  // Read port.
  always_comb begin
    rframe_c       = '0;
    rframe_c.v     = v_q[addr];
    rframe_c.dirty = dirty_q[addr];
    rframe_c.tag   = tag_q[addr];
    rframe_c.data  = data_q[addr];
  end

endmodule

// File: rtl/cache_sram.sv
// Set-array storage and access sequencer for the dcache.
// Accepts one full-set read or write at a time from IDLE, holds the request
// for LAT cycles, then shows ACCESS for one cycle. Address and store image are
// latched at acceptance; cacheline only changes when a read completes.
// Optional feature macro: CACHE_SRAM_INIT_EN -- after reset, sweep all sets
// clearing v/dirty (sramstate = INIT for SETS cycles) instead of resetting
// those bits asynchronously.
// Ports:
//   CLK        clock
//   nRST       async active-low reset
//   sramREN    read-set request
//   sramWEN    write-set request (wins over sramREN)
//   sramaddr   set index
//   ramstore   set image to write (all ways)
//   sramstate  FREE / BUSY / ACCESS / INIT (registered)
//   cacheline  last read set image (registered)
module cache_sram
  import cache_types_package::*;
#(
  parameter int unsigned WAYS  = CACHE_WAYS,
  parameter int unsigned SETS  = CACHE_SETS,
  parameter int unsigned WORDS = CACHE_WORDS,
  parameter int unsigned TAG_W = CACHE_TAG_W,
  parameter int unsigned LAT   = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    sramREN,
  input  logic                    sramWEN,
  input  logic [$clog2(SETS)-1:0] sramaddr,
  input  cacheline_t              ramstore,
  output sramstate_t              sramstate,
  output cacheline_t              cacheline
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

`ifdef CACHE_SRAM_INIT_EN
  localparam fsm_t       RST_STATE = S_INIT;
  localparam sramstate_t RST_CODE  = INIT;
`else
  localparam fsm_t       RST_STATE = S_IDLE;
  localparam sramstate_t RST_CODE  = FREE;
`endif

  fsm_t             state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  cacheline_t       store_q, store_nxt;
  cacheline_t       line_nxt;
  cacheline_t       rd_line_c;
  frame_t           rd_frame_c [WAYS];
  logic             we_c;
  logic [IDX_W-1:0] arr_addr_c;
`ifdef CACHE_SRAM_INIT_EN
  logic [IDX_W-1:0] init_idx_q, init_idx_nxt;
  logic             clr_c;
`endif

  // State, latches and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      idx_q      <= '0;
      store_q    <= '0;
      cacheline  <= '0;
      sramstate  <= RST_CODE;
`ifdef CACHE_SRAM_INIT_EN
      init_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      idx_q      <= idx_nxt;
      store_q    <= store_nxt;
      cacheline  <= line_nxt;
      sramstate  <= sram_encode(state_nxt);
`ifdef CACHE_SRAM_INIT_EN
      init_idx_q <= init_idx_nxt;
`endif
    end
  end

  // Next-state, latch updates and array strobes.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    idx_nxt   = idx_q;
    store_nxt = store_q;
    line_nxt  = cacheline;
    we_c      = 1'b0;
`ifdef CACHE_SRAM_INIT_EN
    init_idx_nxt = init_idx_q;
    clr_c        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (sramWEN) begin
          idx_nxt   = sramaddr;
          store_nxt = ramstore;
          cnt_nxt   = CNT_W'(LAT - 1);
          state_nxt = S_WBUSY;
        end else if (sramREN) begin
          idx_nxt   = sramaddr;
          cnt_nxt   = CNT_W'(LAT - 1);
          state_nxt = S_RBUSY;
        end
      end
      S_RBUSY: begin
        if (cnt_q == '0) begin
          line_nxt  = rd_line_c;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      S_WBUSY: begin
        if (cnt_q == '0) begin
          we_c      = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: state_nxt = S_IDLE;
`ifdef CACHE_SRAM_INIT_EN
      S_INIT: begin
        clr_c        = 1'b1;
        init_idx_nxt = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(SETS - 1)) begin
          state_nxt = S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Array index: the sweep pointer while initialising, else the latched index.
`ifdef CACHE_SRAM_INIT_EN
  assign arr_addr_c = (state_q == S_INIT) ? init_idx_q : idx_q;
`else
  assign arr_addr_c = idx_q;
`endif

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_sram_way #(
      .SETS  (SETS),
      .TAG_W (TAG_W),
      .WORDS (WORDS)
    ) u_way (
      .CLK      (CLK),
`ifdef CACHE_SRAM_INIT_EN
      .clr      (clr_c),
`else
      .nRST     (nRST),
`endif
      .we       (we_c),
      .addr     (arr_addr_c),
      .wframe   (store_q.set[g]),
      .rframe_c (rd_frame_c[g])
    );
  end

  // Gather the per-way read ports into one set image.
  always_comb begin
    rd_line_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      rd_line_c.set[w] = rd_frame_c[w];
    end
  end

endmodule

// File: tb/tb_cache_sram.sv
// Directed bench for cache_sram (default parameters, LAT = 2, SETS = 16).
// Also runs with CACHE_SRAM_INIT_EN defined.
module tb_cache_sram;
  import cache_types_package::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned IDX_W = $clog2(CACHE_SETS);
`ifdef CACHE_SRAM_INIT_EN
  localparam sramstate_t RST_CODE = INIT;
`else
  localparam sramstate_t RST_CODE = FREE;
`endif

  logic             CLK = 1'b0;
  logic             nRST;
  logic             sramREN;
  logic             sramWEN;
  logic [IDX_W-1:0] sramaddr;
  cacheline_t       ramstore;
  sramstate_t       sramstate;
  cacheline_t       cacheline;

  int n_vec = 0;
  int n_err = 0;

  cache_sram #(.LAT(LAT)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .sramREN   (sramREN),
    .sramWEN   (sramWEN),
    .sramaddr  (sramaddr),
    .ramstore  (ramstore),
    .sramstate (sramstate),
    .cacheline (cacheline)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic frame_t mk_frame(input logic v, input logic d,
                                      input logic [CACHE_TAG_W-1:0] t,
                                      input logic [31:0] base);
    frame_t f;
    f.v     = v;
    f.dirty = d;
    f.tag   = t;
    for (int k = 0; k < CACHE_WORDS; k++) f.data[k] = base + 32'(k);
    return f;
  endfunction

  function automatic cacheline_t mk_line(input frame_t f0, input frame_t f1);
    cacheline_t l;
    l.set[0] = f0;
    l.set[1] = f1;
    return l;
  endfunction

  task automatic check_line(input string tag, input cacheline_t exp);
    for (int w = 0; w < CACHE_WAYS; w++) begin
      check($sformatf("%s_w%0d_v", tag, w), 64'(cacheline.set[w].v), 64'(exp.set[w].v));
      check($sformatf("%s_w%0d_dirty", tag, w), 64'(cacheline.set[w].dirty), 64'(exp.set[w].dirty));
      check($sformatf("%s_w%0d_tag", tag, w), 64'(cacheline.set[w].tag), 64'(exp.set[w].tag));
      for (int k = 0; k < CACHE_WORDS; k++)
        check($sformatf("%s_w%0d_d%0d", tag, w, k),
              64'(cacheline.set[w].data[k]), 64'(exp.set[w].data[k]));
    end
  endtask

  // One request: accepted at the first edge, then sramaddr/ramstore are
  // disturbed to prove the latched copies are used.
  task automatic op(input logic wen, input logic ren, input logic [IDX_W-1:0] idx,
                    input logic [IDX_W-1:0] idx_late, input cacheline_t st, input string tag);
    int n;
    sramWEN  = wen;
    sramREN  = ren;
    sramaddr = idx;
    ramstore = st;
    tick();
    sramWEN  = 1'b0;
    sramREN  = 1'b0;
    sramaddr = idx_late;
    ramstore = ~st;
    check({tag, "_busy"}, 64'(sramstate), 64'(BUSY));
    n = 0;
    while (sramstate != ACCESS && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(LAT));
    tick();
    check({tag, "_free"}, 64'(sramstate), 64'(FREE));
  endtask

  // After a reset release: INIT sweep (with the macro) or straight to FREE.
  task automatic wait_init(input string tag);
`ifdef CACHE_SRAM_INIT_EN
    int n;
    n        = 0;
    sramREN  = 1'b1;
    sramaddr = IDX_W'(6);
    do begin
      tick();
      n++;
      if (n == 3) sramREN = 1'b0;
    end while (sramstate == INIT && n < 40);
    check({tag, "_init_cycles"}, 64'(n), 64'(CACHE_SETS));
    check({tag, "_init_end"}, 64'(sramstate), 64'(FREE));
    tick();
    check({tag, "_ren_ignored"}, 64'(sramstate), 64'(FREE));
`else
    check({tag, "_free"}, 64'(sramstate), 64'(FREE));
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cacheline_t a, b, c, d, e, f, z, exp;
    int n;

    a = mk_line(mk_frame(1'b1, 1'b1, 26'h0AB, 32'h100), mk_frame(1'b1, 1'b0, 26'h3FFFFFF, 32'hDEAD0000));
    b = mk_line(mk_frame(1'b1, 1'b0, 26'h012, 32'h1),   mk_frame(1'b0, 1'b1, 26'h055, 32'h50));
    c = mk_line(mk_frame(1'b1, 1'b1, 26'h077, 32'h700), mk_frame(1'b1, 1'b0, 26'h078, 32'h780));
    d = mk_line(mk_frame(1'b1, 1'b0, 26'h022, 32'h200), mk_frame(1'b1, 1'b1, 26'h023, 32'h280));
    e = mk_line(mk_frame(1'b1, 1'b1, 26'h099, 32'h900), mk_frame(1'b0, 1'b0, 26'h09A, 32'h980));
    f = mk_line(mk_frame(1'b1, 1'b1, 26'h0FF, 32'hF00), mk_frame(1'b1, 1'b1, 26'h0FE, 32'hF80));
    z = '0;

    nRST     = 1'b0;
    sramREN  = 1'b0;
    sramWEN  = 1'b0;
    sramaddr = '0;
    ramstore = '0;
    #12;
    check("rst_state", 64'(sramstate), 64'(RST_CODE));
    check("rst_line_zero", 64'(|cacheline), 64'd0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    wait_init("boot");

    // Read of set 3 straight after reset: timing step by step.
    sramREN  = 1'b1;
    sramaddr = IDX_W'(3);
    tick();
    sramREN = 1'b0;
    check("rd3_t1_busy", 64'(sramstate), 64'(BUSY));
    tick();
    check("rd3_t1b_busy", 64'(sramstate), 64'(BUSY));
    tick();
    check("rd3_t2_access", 64'(sramstate), 64'(ACCESS));
    check("rd3_w0_v", 64'(cacheline.set[0].v), 64'd0);
    check("rd3_w1_v", 64'(cacheline.set[1].v), 64'd0);
    tick();
    check("rd3_t3_free", 64'(sramstate), 64'(FREE));

    // Every set reads invalid and clean.
    for (int i = 0; i < CACHE_SETS; i++) begin
      op(1'b0, 1'b1, IDX_W'(i), IDX_W'(i), z, $sformatf("sweep%0d", i));
      for (int w = 0; w < CACHE_WAYS; w++) begin
        check($sformatf("sweep%0d_w%0d_v", i, w), 64'(cacheline.set[w].v), 64'd0);
        check($sformatf("sweep%0d_w%0d_dirty", i, w), 64'(cacheline.set[w].dirty), 64'd0);
      end
    end

    // Known contents in set 4, read back.
    op(1'b1, 1'b0, IDX_W'(4), IDX_W'(4), a, "wr4");
    op(1'b0, 1'b1, IDX_W'(4), IDX_W'(4), z, "rd4");
    check_line("rd4", a);

    // Write set 5; cacheline must keep set 4's image, then read set 5.
    op(1'b1, 1'b0, IDX_W'(5), IDX_W'(5), b, "wr5");
    check_line("wr5_keep", a);
    op(1'b0, 1'b1, IDX_W'(5), IDX_W'(5), z, "rd5");
    check("rd5_w0_tag", 64'(cacheline.set[0].tag), 64'h12);
    check("rd5_w0_d2", 64'(cacheline.set[0].data[2]), 64'd3);
    check("rd5_w0_v", 64'(cacheline.set[0].v), 64'd1);
    check_line("rd5", b);

    // REN and WEN together on set 7: write wins; held REN is served afterwards.
    sramWEN  = 1'b1;
    sramREN  = 1'b1;
    sramaddr = IDX_W'(7);
    ramstore = c;
    tick();
    sramWEN  = 1'b0;
    ramstore = z;
    check("both7_busy", 64'(sramstate), 64'(BUSY));
    n = 0;
    while (sramstate != ACCESS && n < 20) begin
      tick();
      n++;
    end
    check("both7_wr_lat", 64'(n), 64'(LAT));
    check_line("both7_keep", b);
    tick();
    check("both7_free", 64'(sramstate), 64'(FREE));
    n = 0;
    while (sramstate != ACCESS && n < 20) begin
      tick();
      n++;
    end
    sramREN = 1'b0;
    check("both7_rd_lat", 64'(n), 64'(LAT + 1));
    check_line("both7_rd", c);
    tick();
    check("both7_rd_free", 64'(sramstate), 64'(FREE));

    // Address moves 2 -> 9 during BUSY: the operation stays on set 2.
    op(1'b1, 1'b0, IDX_W'(9), IDX_W'(9), e, "wr9");
    op(1'b1, 1'b0, IDX_W'(2), IDX_W'(9), d, "wr2mv");
    op(1'b0, 1'b1, IDX_W'(9), IDX_W'(9), z, "rd9");
    check_line("rd9", e);
    op(1'b0, 1'b1, IDX_W'(2), IDX_W'(9), z, "rd2mv");
    check_line("rd2mv", d);

    // Reset pulse while a write to set 4 is still counting: write dropped.
    sramWEN  = 1'b1;
    sramaddr = IDX_W'(4);
    ramstore = f;
    tick();
    sramWEN = 1'b0;
    tick();
    nRST = 1'b0;
    #2;
    check("pulse_state", 64'(sramstate), 64'(RST_CODE));
    check("pulse_line_zero", 64'(|cacheline), 64'd0);
    #1;
    nRST = 1'b1;
    wait_init("pulse");
    op(1'b0, 1'b1, IDX_W'(4), IDX_W'(4), z, "rd4b");
    exp = a;
    for (int w = 0; w < CACHE_WAYS; w++) begin
      exp.set[w].v     = 1'b0;
      exp.set[w].dirty = 1'b0;
    end
    check_line("rd4b", exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
